// File: rtl/float16_fixed_conv_pkg.sv
// Shared widths, constants and helpers for the half-float <-> Q17.25 converter.
package f16_fixed_pkg;
    localparam int FLT_W           = 16;
    localparam int EXP_W           = 5;
    localparam int MAN_W           = 10;
    localparam int EXP_BIAS        = 15;
    localparam int FIX_W           = 43;
    localparam int FRAC_BITS       = 25;
    localparam int ZERO_THRESH_MSB = 10;
    // Magnitude width once the sign bit is stripped.
    localparam int MAG_W           = FIX_W - 1;
    // Leading-one detector works on 6 groups of 7 bits.
    localparam int LZC_GRP_W       = 7;
    localparam int LZC_NGRP        = MAG_W / LZC_GRP_W;

    localparam logic [FLT_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [FLT_W-1:0] SAT_NEG = 16'hFFFF;

    // Index of the highest set bit in a 7-bit group (0 when the group is empty).
    function automatic logic [2:0] msb7(input logic [LZC_GRP_W-1:0] v);
        msb7 = 3'd0;
        for (int i = 0; i < LZC_GRP_W; i++)
            if (v[i]) msb7 = 3'(i);
    endfunction
endpackage

// File: rtl/float16_fixed_conv_if.sv
// Data bus of the converter: both conversion paths, no handshake.
interface float16_fixed_conv_if;
    import f16_fixed_pkg::*;

    logic [FLT_W-1:0] float_in;
    logic [FIX_W-1:0] fixed_out;
    logic [FIX_W-1:0] fixed_in;
    logic [FLT_W-1:0] float_out;

    modport master (output float_in, fixed_in, input fixed_out, float_out);
    modport slave  (input float_in, fixed_in, output fixed_out, float_out);
endinterface

// File: rtl/float16_fixed_conv_lzc.sv
// Two-stage leading-one detector over a 42-bit magnitude.
// Stage A finds the top bit inside each 7-bit group, stage B picks the
// highest non-empty group. Result is valid two cycles after data.
module f16_lzc42
    import f16_fixed_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [MAG_W-1:0] data,
    output logic [5:0]       msb,
    output logic             any
);
    logic [LZC_NGRP-1:0]       grp_nz_c, grp_nz;
    logic [LZC_NGRP-1:0][2:0]  grp_idx_c, grp_idx;
    logic [5:0]                msb_c;

    for (genvar g = 0; g < LZC_NGRP; g++) begin : g_grp
        assign grp_nz_c[g]  = |data[g*LZC_GRP_W +: LZC_GRP_W];
        assign grp_idx_c[g] = msb7(data[g*LZC_GRP_W +: LZC_GRP_W]);
    end

    // Stage B: the highest occupied group wins.
    always_comb begin
        msb_c = '0;
        for (int g = 0; g < LZC_NGRP; g++)
            if (grp_nz[g]) msb_c = 6'(g * LZC_GRP_W) + {3'b000, grp_idx[g]};
    end

    // Per-group results, then the merged index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grp_nz  <= '0;
            grp_idx <= '0;
            msb     <= '0;
            any     <= 1'b0;
        end else begin
            grp_nz  <= grp_nz_c;
            grp_idx <= grp_idx_c;
            msb     <= msb_c;
            any     <= |grp_nz;
        end
    end
endmodule

// File: rtl/float16_fixed_conv.sv
// Half-float <-> Q17.25 converter with two independent pipelines.
// float -> fixed: 2 cycles, exact. fixed -> float: 5 cycles.
// Build option F16_FIXED_ROUND_EN: round-to-nearest (ties away) on the
// first discarded bit; otherwise the magnitude is truncated.
module float16_fixed_conv
    import f16_fixed_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    float16_fixed_conv_if.slave bus
);
`ifdef F16_FIXED_ROUND_EN
    localparam logic ROUND_ON = 1'b1;
`else
    localparam logic ROUND_ON = 1'b0;
`endif
    localparam int TOP_W = MAN_W + 1;

    // ---------------- float -> fixed ----------------
    logic             f2x_zero, f2x_sign;
    logic [MAG_W-1:0] f2x_mag_c, f2x_mag;

    // Exponents 0 and 31 are ordinary; only +/-0 codes map to zero.
    assign f2x_zero  = (bus.float_in[FLT_W-2:0] == '0);
    assign f2x_mag_c = MAG_W'({1'b1, bus.float_in[MAN_W-1:0]}) << bus.float_in[FLT_W-2 -: EXP_W];

    // Stage 1 shifts the significand into place, stage 2 applies the sign.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f2x_mag       <= '0;
            f2x_sign      <= 1'b0;
            bus.fixed_out <= '0;
        end else begin
            f2x_mag       <= f2x_zero ? '0 : f2x_mag_c;
            f2x_sign      <= bus.float_in[FLT_W-1];
            bus.fixed_out <= f2x_sign ? -{1'b0, f2x_mag} : {1'b0, f2x_mag};
        end
    end

    // ---------------- fixed -> float ----------------
    logic [FIX_W-1:0] abs_c, mag1, mag2, mag3;
    logic [2:0]       sign_pipe;
    logic [5:0]       lz_msb, sh_c;
    logic             lz_any, zero_c;
    logic [TOP_W-1:0] top_c;
    logic             s4_sign, s4_sat, s4_zero, s4_rnd;
    logic [EXP_W-1:0] s4_exp;
    logic [MAN_W-1:0] s4_man;
    logic [TOP_W-1:0] man_sum;
    logic             carry, sat_c;
    logic [FLT_W-1:0] pack_c;

    // Most negative input negates to itself, leaving bit 42 set as a saturate flag.
    assign abs_c = bus.fixed_in[FIX_W-1] ? -bus.fixed_in : bus.fixed_in;

    f16_lzc42 u_lzc (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (mag1[MAG_W-1:0]),
        .msb     (lz_msb),
        .any     (lz_any)
    );

    // Align leading one to bit 11 of a 12-bit window: man in [10:1], round bit in [0].
    assign sh_c   = lz_msb - 6'(MAN_W);
    assign top_c  = TOP_W'({mag3[MAG_W-1:0], 1'b0} >> sh_c);
    assign zero_c = !lz_any || (lz_msb < 6'(ZERO_THRESH_MSB));

    // Absolute value, then magnitude/sign delayed alongside the detector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mag1      <= '0;
            mag2      <= '0;
            mag3      <= '0;
            sign_pipe <= '0;
        end else begin
            mag1      <= abs_c;
            mag2      <= mag1;
            mag3      <= mag2;
            sign_pipe <= {sign_pipe[1:0], bus.fixed_in[FIX_W-1]};
        end
    end

    // Stage 4: normalised fields and flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s4_sign <= 1'b0;
            s4_sat  <= 1'b0;
            s4_zero <= 1'b0;
            s4_rnd  <= 1'b0;
            s4_exp  <= '0;
            s4_man  <= '0;
        end else begin
            s4_sign <= sign_pipe[2];
            s4_sat  <= mag3[FIX_W-1];
            s4_zero <= zero_c;
            s4_rnd  <= top_c[0] & ROUND_ON;
            s4_exp  <= EXP_W'(sh_c);
            s4_man  <= top_c[TOP_W-1:1];
        end
    end

    assign man_sum = {1'b0, s4_man} + TOP_W'(s4_rnd);
    assign carry   = man_sum[MAN_W];
    assign sat_c   = s4_sat || (!s4_zero && carry && (s4_exp == '1));

    // Pack the result: mantissa carry bumps exp, small values flush to +0, overflow saturates.
    always_comb begin
        pack_c = {s4_sign, s4_exp, man_sum[MAN_W-1:0]};
        if (carry)   pack_c = {s4_sign, EXP_W'(s4_exp + 1'b1), {MAN_W{1'b0}}};
        if (s4_zero) pack_c = '0;
        if (sat_c)   pack_c = s4_sign ? SAT_NEG : SAT_POS;
    end

    // Stage 5: output register.
    always_ff @(posedge clk) begin
        if (!reset_n) bus.float_out <= '0;
        else          bus.float_out <= pack_c;
    end
endmodule

// File: tb/tb_float16_fixed_conv.sv
// Scoreboard bench for float16_fixed_conv: directed vectors on both paths,
// mid-stream resets, and a float->fixed->float loop-back run.
module tb_float16_fixed_conv;
    import f16_fixed_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    float16_fixed_conv_if bus();

    float16_fixed_conv dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic        loop_mode = 1'b0;
    logic [42:0] x_drv = '0;
    always_comb bus.fixed_in = loop_mode ? bus.fixed_out : x_drv;

`ifdef F16_FIXED_ROUND_EN
    localparam logic [15:0] E_TIE  = 16'h3C01;
    localparam logic [15:0] E_CRY  = 16'h4000;
    localparam logic [15:0] E_NTIE = 16'hBC01;
`else
    localparam logic [15:0] E_TIE  = 16'h3C00;
    localparam logic [15:0] E_CRY  = 16'h3FFF;
    localparam logic [15:0] E_NTIE = 16'hBC00;
`endif

    logic [15:0] f_vec [8] = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000,
                               16'h0001, 16'h7FFF, 16'h4000, 16'hFBFF};
    logic [42:0] f_exp [8] = '{43'h00002000000, 43'h7FFFE000000, 43'h0, 43'h0,
                               43'h00000000401, 43'h3FF80000000, 43'h00004000000,
                               43'h60040000000};
    logic [42:0] x_vec [14] = '{43'h00002000000, 43'h1, 43'h3FF, 43'h400,
                                43'h7FFFFFFFC00, 43'h00002001000, 43'h00002004000,
                                43'h3FFFFFFFFFF, 43'h7FFFE000000, 43'h40000000000,
                                43'h3FF80000000, 43'h00003FFE000, 43'h7FFFDFFC000,
                                43'h7FFFFFFFC01};
    logic [15:0] x_exp [14] = '{16'h3C00, 16'h0000, 16'h0000, 16'h0000,
                                16'h8000, 16'h3C00, E_TIE, 16'h7FFF,
                                16'hBC00, 16'hFFFF, 16'h7FFF, E_CRY,
                                E_NTIE, 16'h0000};

    logic        f_issue = 1'b0, x_issue = 1'b0, rt_issue = 1'b0;
    logic [1:0]  fx_pipe = '0;
    logic [4:0]  fl_pipe = '0;
    logic [6:0]  rt_pipe = '0;
    int          zc_fx = 0, zc_fl = 0;
    logic [42:0] q_fx [$];
    logic [15:0] q_fl [$];
    logic [15:0] q_rt [$];
    int          n_vec = 0, n_err = 0;
    logic        finish_req = 1'b0;

    // Track in-flight issues; a reset discards them and opens zero-output windows.
    always @(posedge clk) begin
        if (!reset_n) begin
            fx_pipe <= '0;
            fl_pipe <= '0;
            rt_pipe <= '0;
            q_fx.delete();
            q_fl.delete();
            q_rt.delete();
            zc_fx <= 2;
            zc_fl <= 5;
        end else begin
            fx_pipe <= {fx_pipe[0], f_issue};
            fl_pipe <= {fl_pipe[3:0], x_issue};
            rt_pipe <= {rt_pipe[5:0], rt_issue};
            if (zc_fx > 0) zc_fx <= zc_fx - 1;
            if (zc_fl > 0) zc_fl <= zc_fl - 1;
        end
    end

    task automatic chk(input string nm, input logic [42:0] act, input logic [42:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs against queued expectations on the falling edge.
    always @(negedge clk) begin
        if (fx_pipe[1]) begin
            if (q_fx.size() == 0) chk("fixed_out_queue_empty", 43'h1, 43'h0);
            else chk("fixed_out", bus.fixed_out, q_fx.pop_front());
        end
        if (fl_pipe[4]) begin
            if (q_fl.size() == 0) chk("float_out_queue_empty", 43'h1, 43'h0);
            else chk("float_out", 43'(bus.float_out), 43'(q_fl.pop_front()));
        end
        if (rt_pipe[6]) begin
            if (q_rt.size() == 0) chk("loop_queue_empty", 43'h1, 43'h0);
            else chk("loop_float_out", 43'(bus.float_out), 43'(q_rt.pop_front()));
        end
        if (zc_fx > 0) chk("fixed_out_reset", bus.fixed_out, 43'h0);
        if (zc_fl > 0) chk("float_out_reset", 43'(bus.float_out), 43'h0);
        if (finish_req) begin
            chk("leftover_expectations", 43'(q_fx.size() + q_fl.size() + q_rt.size()), 43'h0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    task automatic cyc(input logic rn, input logic fv, input logic [15:0] f, input logic [42:0] fe,
                       input logic xv, input logic [42:0] x, input logic [15:0] xe, input logic rv);
        @(posedge clk);
        #1;
        reset_n      = rn;
        bus.float_in = f;
        x_drv        = x;
        f_issue      = fv;
        x_issue      = xv;
        rt_issue     = rv;
        if (fv) q_fx.push_back(fe);
        if (xv) q_fl.push_back(xe);
        if (rv) q_rt.push_back((f == 16'h8000) ? 16'h0000 : f);
    endtask

    initial begin
        logic [15:0] f;
        logic [42:0] fe;
        bus.float_in = '0;
        repeat (3) cyc(1'b0, 1'b0, 16'h0, 43'h0, 1'b0, 43'h0, 16'h0, 1'b0);

        // Directed vectors on both paths in parallel.
        for (int i = 0; i < 14; i++) begin
            f = 16'h0; fe = 43'h0;
            if (i < 8) begin f = f_vec[i]; fe = f_exp[i]; end
            cyc(1'b1, i < 8, f, fe, 1'b1, x_vec[i], x_exp[i], 1'b0);
        end
        repeat (6) cyc(1'b1, 1'b0, 16'h0, 43'h0, 1'b0, 43'h0, 16'h0, 1'b0);

        // One-cycle reset in the middle of a stream.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, f_vec[i], f_exp[i], 1'b1, x_vec[i], x_exp[i], 1'b0);
        cyc(1'b0, 1'b0, 16'h3C00, 43'h0, 1'b0, 43'h00002000000, 16'h0, 1'b0);
        for (int i = 3; i < 8; i++)
            cyc(1'b1, 1'b1, f_vec[i], f_exp[i], 1'b1, x_vec[i+3], x_exp[i+3], 1'b0);
        repeat (6) cyc(1'b1, 1'b0, 16'h0, 43'h0, 1'b0, 43'h0, 16'h0, 1'b0);

        // Loop-back: fixed_out feeds fixed_in, float_out must reproduce float_in.
        loop_mode = 1'b1;
        for (int i = 0; i < 50; i++) begin
            case (i)
                3:       f = 16'h8000;
                4:       f = 16'h0000;
                5:       f = 16'h7FFF;
                6:       f = 16'h0001;
                default: f = 16'($urandom);
            endcase
            if (i == 25) cyc(1'b0, 1'b0, f, 43'h0, 1'b0, 43'h0, 16'h0, 1'b0);
            else         cyc(1'b1, 1'b0, f, 43'h0, 1'b0, 43'h0, 16'h0, 1'b1);
        end
        repeat (10) cyc(1'b1, 1'b0, 16'h0, 43'h0, 1'b0, 43'h0, 16'h0, 1'b0);

        finish_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "bench did not terminate");
    end
endmodule

// File: doc/float16_fixed_conv.md
FLOAT16_FIXED_CONV -- requirements
Module: float16_fixed_conv

Interface
REQ-001 No parameters; all widths are fixed constants held in the shared package.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 float_in  input  16  half-float: sign[15], exp[14:10] (bias 15), man[9:0].
REQ-005 fixed_out  output  43  signed two's-complement Q17.25 (LSB = 2^-25) value of float_in.
REQ-006 fixed_in  input  43  signed two's-complement Q17.25 value.
REQ-007 float_out  output  16  half-float encoding of fixed_in.

Function
REQ-008 The block SHALL contain two independent, fully pipelined paths, each accepting one new input every cycle with no handshake.
REQ-009 Float-to-fixed latency SHALL be exactly 2 cycles; fixed-to-float latency SHALL be exactly 5 cycles; a float-to-fixed result fed straight back costs 7 cycles total.
REQ-010 Float-to-fixed: float_in[14:0]==0 SHALL give fixed_out 0, including for 0x8000.
REQ-011 Float-to-fixed: any other code SHALL be decoded as a normal number (-1)^s * 1.man * 2^(exp-15), with exp 0 and exp 31 treated as ordinary exponents; there are no denormals, Inf or NaN.
REQ-012 Float-to-fixed conversion SHALL be exact; the magnitude is {1,man} shifted left by exp, occupying bits up to 2^42-2^31, and is negated when sign=1.
REQ-013 Fixed-to-float: |fixed_in| < 2^-15 (magnitude < 2^10 LSB) SHALL give float_out 0x0000; zero always has sign 0.
REQ-014 Fixed-to-float: otherwise sign = fixed_in[42].
REQ-015 Fixed-to-float: the magnitude SHALL be normalised by leading-one position, with exp = msb_index - 10 (range 0..31).
REQ-016 Fixed-to-float: the 10 bits below the leading one form the mantissa.
REQ-017 Fixed-to-float rounding SHALL be round-to-nearest, ties away from zero, using only the first discarded bit; a mantissa carry SHALL increment exp.
REQ-018 Fixed-to-float: a rounding carry out of exp 31, or a magnitude of 2^42 (input 43'h40000000000), SHALL saturate to exp 31 / man 0x3FF (0x7FFF or 0xFFFF).

Reset
REQ-019 While reset_n=0 at a clock edge, all pipeline registers SHALL clear, so fixed_out=0 and float_out=0x0000.
REQ-020 On reset mid-stream, all in-flight data SHALL be discarded.
REQ-021 After release, outputs SHALL remain 0 until the first post-reset input emerges after its path latency.

Configuration
REQ-022 With F16_FIXED_ROUND_EN defined, fixed-to-float SHALL round per REQ-017/REQ-018.
REQ-023 Without F16_FIXED_ROUND_EN, fixed-to-float SHALL truncate the magnitude toward zero; latency and all other behaviour are unchanged.

Structure
REQ-024 Package f16_fixed_pkg SHALL hold FLT_W=16, EXP_W=5, MAN_W=10, EXP_BIAS=15, FIX_W=43, FRAC_BITS=25, ZERO_THRESH_MSB=10 and the saturation codes 16'h7FFF/16'hFFFF.
REQ-025 Leading-one detection on the 42-bit magnitude SHALL be a sub-module, f16_lzc42, pipelined within the 5-cycle budget.

Verification
REQ-026 float_in 0x3C00 / 0xBC00 -> fixed_out 43'h00002000000 / 43'h7FFFE000000, 2 cycles later.
REQ-027 float_in 0x0000, 0x8000, 0x0001, 0x7FFF -> fixed_out 0, 0, 43'h00000000401, 43'h3FF80000000.
REQ-028 fixed_in 43'h00002000000, 1, 43'h000000003FF -> float_out 0x3C00, 0x0000, 0x0000, 5 cycles later.
REQ-029 Rounding (ROUND_EN on): fixed_in 43'h00002001000 -> 0x3C00; 43'h00002004000 (tie) -> 0x3C01; 43'h3FFFFFFFFFF -> 0x7FFF; 43'h7FFFE000000 -> 0xBC00. With ROUND_EN off, 43'h00002004000 -> 0x3C00.
REQ-030 Random float_in every cycle, fixed_out looped to fixed_in -> float_out equals float_in after 7 cycles, with 0x8000 mapping to 0x0000.
REQ-031 Assert reset_n=0 for 1 cycle mid-stream -> both outputs are 0 for the next 2 (fixed_out) and 5 (float_out) cycles, then valid data resumes.
